// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register: operating-mode encoding.
// The bench imports the same package so both sides agree on the mode values.
package shift_reg_univ_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_reg_cell.sv
// One register bit: a 4:1 mux (hold/right/left/load) feeding a D flop with async reset.
// The mux output is also exported so the parent can count transitions before they happen.
module shift_reg_cell
  import shift_reg_univ_pkg::*;
#(
  parameter int PwrC = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       enb,
  input  logic [1:0] mode,
  input  logic       right_in,
  input  logic       left_in,
  input  logic       load_in,
  output logic       q,
  output logic       q_next
);

  logic q_d;
  logic q_q;

  // PwrC tags the cell for the power-estimation flow only; negative indices are not meaningful.
  if (PwrC < 0) begin : g_pwrc_unused
  end

  always_comb begin
    q_d = q_q;
    if (enb) begin
      case (mode_e'(mode))
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = right_in;
        MODE_SHL:  q_d = left_in;
        MODE_LOAD: q_d = load_in;
        default:   q_d = q_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all cells sample
  // their neighbours' pre-edge values, which is what makes the shift work.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q      = q_q;
  assign q_next = q_d;

endmodule

// File: rtl/shift_reg_univ.sv
// N-bit universal register (hold / shift right / shift left / load, optional rotate)
// with a registered serial output and a saturating count of Q bit transitions.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int N    = 4,
  parameter int PwrC = 0,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ENB,
  input  logic [1:0]      MODE,
  input  logic            ROT,
  input  logic            S_IN,
  input  logic [N-1:0]    D,
  output logic [N-1:0]    Q,
  output logic            S_OUT,
  output logic [CNTW-1:0] TOGGLES
);

  localparam int POPW = $clog2(N) + 1;
  localparam int SUMW = CNTW + POPW;

  if (N < 2) begin : g_width_too_small
  end

  logic [N-1:0]    q_bits;
  logic [N-1:0]    q_nxt;
  logic            si_right;
  logic            si_left;
  logic            s_out_d;
  logic            s_out_q;
  logic [POPW-1:0] pop_cnt;
  logic [SUMW-1:0] toggle_sum;
  logic [CNTW-1:0] toggles_d;
  logic [CNTW-1:0] toggles_q;

  // End bits take either the serial input or the bit falling off the other end.
  assign si_right = ROT ? q_bits[0]   : S_IN;
  assign si_left  = ROT ? q_bits[N-1] : S_IN;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic right_in;
    logic left_in;

    if (i == N - 1) begin : g_msb
      assign right_in = si_right;
    end else begin : g_mid_r
      assign right_in = q_bits[i+1];
    end

    if (i == 0) begin : g_lsb
      assign left_in = si_left;
    end else begin : g_mid_l
      assign left_in = q_bits[i-1];
    end

    shift_reg_cell #(
      .PwrC (PwrC)
    ) u_cell (
      .CLK      (CLK),
      .RESET    (RESET),
      .enb      (ENB),
      .mode     (MODE),
      .right_in (right_in),
      .left_in  (left_in),
      .load_in  (D[i]),
      .q        (q_bits[i]),
      .q_next   (q_nxt[i])
    );
  end

  always_comb begin
    s_out_d = s_out_q;
    if (ENB) begin
      if (mode_e'(MODE) == MODE_SHR)      s_out_d = q_bits[0];
      else if (mode_e'(MODE) == MODE_SHL) s_out_d = q_bits[N-1];
    end
  end

  // Transitions are counted from the cells' own next values, so a load of an
  // equal value or a rotate of a uniform word contributes nothing.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + POPW'(q_bits[i] ^ q_nxt[i]);
    end
    toggle_sum = SUMW'(toggles_q) + SUMW'(pop_cnt);
    if (toggle_sum > SUMW'({CNTW{1'b1}})) toggles_d = '1;
    else                                  toggles_d = toggle_sum[CNTW-1:0];
  end

  // NOTE: reset is asynchronous: it clears the flops the moment RESET rises,
  // so it must appear in the sensitivity list, not only inside the block.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s_out_q   <= 1'b0;
      toggles_q <= '0;
    end else begin
      s_out_q   <= s_out_d;
      toggles_q <= toggles_d;
    end
  end

  assign Q       = q_bits;
  assign S_OUT   = s_out_q;
  assign TOGGLES = toggles_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: async reset, load, shifts, rotates, enable gating
// and counter saturation (second instance with a 4-bit counter).
module tb_shift_reg_univ;
  import shift_reg_univ_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENB;
  logic [1:0]  MODE;
  logic        ROT;
  logic        S_IN;
  logic [3:0]  D;
  logic [3:0]  q;
  logic        s_out;
  logic [15:0] toggles;
  logic [3:0]  q_sat;
  logic        s_out_sat;
  logic [3:0]  toggles_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  shift_reg_univ #(.N(4), .PwrC(0), .CNTW(16)) dut (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODE(MODE), .ROT(ROT), .S_IN(S_IN),
    .D(D), .Q(q), .S_OUT(s_out), .TOGGLES(toggles)
  );

  shift_reg_univ #(.N(4), .PwrC(1), .CNTW(4)) dut_sat (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODE(MODE), .ROT(ROT), .S_IN(S_IN),
    .D(D), .Q(q_sat), .S_OUT(s_out_sat), .TOGGLES(toggles_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 ns past it before sampling.
  task automatic step(input logic enb, input mode_e mode, input logic rot,
                      input logic s_in, input logic [3:0] d);
    ENB  = enb;
    MODE = mode;
    ROT  = rot;
    S_IN = s_in;
    D    = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] eq,
                             input logic es, input logic [15:0] et);
    check({tag, ".q"},       32'(q),       32'(eq));
    check({tag, ".s_out"},   32'(s_out),   32'(es));
    check({tag, ".toggles"}, 32'(toggles), 32'(et));
  endtask

  initial begin
    RESET = 1'b1;
    ENB = 1'b0; MODE = MODE_HOLD; ROT = 1'b0; S_IN = 1'b0; D = 4'h0;
    #12;
    check_state("reset", 4'b0000, 1'b0, 16'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Async reset mid-cycle, then release with no edge.
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1011);
    check_state("pre_reset", 4'b1011, 1'b0, 16'd3);
    #2 RESET = 1'b1;
    #1 check_state("async_reset", 4'b0000, 1'b0, 16'd0);
    #1 RESET = 1'b0;
    #1 check_state("reset_release", 4'b0000, 1'b0, 16'd0);

    step(1'b1, MODE_LOAD, 1'b1, 1'b1, 4'b1011);
    check_state("load", 4'b1011, 1'b0, 16'd3);

    step(1'b1, MODE_SHR, 1'b0, 1'b0, 4'b0000);
    check_state("shr_sin0", 4'b0101, 1'b1, 16'd6);

    step(1'b1, MODE_SHL, 1'b1, 1'b1, 4'b1111);
    check_state("rotl_1", 4'b1010, 1'b0, 16'd10);
    step(1'b1, MODE_SHL, 1'b1, 1'b0, 4'b0000);
    step(1'b1, MODE_SHL, 1'b1, 1'b1, 4'b0110);
    step(1'b1, MODE_SHL, 1'b1, 1'b0, 4'b1001);
    check_state("rotl_4", 4'b0101, 1'b1, 16'd22);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, MODE_LOAD, 1'b0, 1'b1, 4'b1111);
    end
    check_state("enb_gated", 4'b0101, 1'b1, 16'd22);
    step(1'b1, MODE_LOAD, 1'b0, 1'b1, 4'b1111);
    check_state("enb_load", 4'b1111, 1'b1, 16'd24);

    step(1'b1, MODE_SHL, 1'b0, 1'b0, 4'b0000);
    check_state("shl_sin0", 4'b1110, 1'b1, 16'd25);
    step(1'b1, MODE_SHR, 1'b0, 1'b1, 4'b0000);
    check_state("shr_sin1", 4'b1111, 1'b0, 16'd26);
    step(1'b1, MODE_HOLD, 1'b1, 1'b0, 4'b0000);
    check_state("hold", 4'b1111, 1'b0, 16'd26);
    step(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
    check_state("rotr_ones", 4'b1111, 1'b1, 16'd26);
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1111);
    check_state("load_equal", 4'b1111, 1'b1, 16'd26);

    // Saturation on the 4-bit counter instance, starting from a fresh reset.
    #2 RESET = 1'b1;
    #2 RESET = 1'b0;
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1111);
    check("sat_1", 32'(toggles_sat), 32'd4);
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b0000);
    check("sat_2", 32'(toggles_sat), 32'd8);
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1111);
    check("sat_3", 32'(toggles_sat), 32'd12);
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b0000);
    check("sat_4", 32'(toggles_sat), 32'd15);
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1111);
    check("sat_5", 32'(toggles_sat), 32'd15);
    check("sat_q", 32'(q_sat), 32'(4'b1111));
    check("wide_after_sat", 32'(toggles), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
